// File: rtl/vector_mem_access.sv
// Memory-stage access unit: scalar pass-through plus multi-beat vector load/store sequencing.
// Optional feature: define VMEM_ALIGN_CHECK_EN to suppress misaligned accesses instead of masking addr[1:0].
module vector_mem_access #(
    parameter int N     = 32,
    parameter int V     = 256,
    parameter int BEATS = V / N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         MemWriteM,
    input  logic         MemtoRegM,
    input  logic         MemDataVM,
    input  logic [N-1:0] ALUResultM,
    input  logic [N-1:0] WriteDataM,
    input  logic [V-1:0] WriteDataVM,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] ReadDataM,
    output logic [V-1:0] ReadDataVM,
    output logic         stall_req,
    output logic         misalign_err
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, VSTORE, VLOAD, VDRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [V-1:0]  rdv_q;
    logic [N-1:0]  addr_raw;
    logic [BW-1:0] cap_idx;
    logic          vec_op, bad_align;

    assign vec_op = MemDataVM & (MemWriteM | MemtoRegM);
`ifdef VMEM_ALIGN_CHECK_EN
    assign bad_align = (MemWriteM | MemtoRegM) & (|ALUResultM[1:0]);
`else
    assign bad_align = 1'b0;
`endif
    // Beat addresses step by one 32-bit word and wrap modulo 2^N.
    assign addr_raw = ALUResultM + {{(N-BW-2){1'b0}}, beat_q, 2'b00};
`ifdef VMEM_ALIGN_CHECK_EN
    assign mem_addr = addr_raw;
`else
    assign mem_addr = {addr_raw[N-1:2], 2'b00};
`endif

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        stall_req    = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = WriteDataM;
        misalign_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (bad_align) begin
                    misalign_err = 1'b1;
                end else if (vec_op) begin
                    stall_req = 1'b1;
                    beat_d    = BW'(1);
                    mem_we    = MemWriteM;
                    mem_wdata = WriteDataVM[N*beat_q +: N];
                    state_d   = MemWriteM ? VSTORE : VLOAD;
                end else begin
                    mem_we = MemWriteM;
                end
            end
            VSTORE: begin
                stall_req = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = WriteDataVM[N*beat_q +: N];
                beat_d    = beat_q + BW'(1);
                if (beat_q == LAST) begin
                    beat_d  = '0;
                    state_d = DONE;
                end
            end
            VLOAD: begin
                stall_req = 1'b1;
                beat_d    = beat_q + BW'(1);
                if (beat_q == LAST) begin
                    beat_d  = '0;
                    state_d = VDRAIN;
                end
            end
            VDRAIN: begin
                stall_req = 1'b1;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data lags issue by one cycle, so VLOAD stores the previous beat's word.
    assign cap_idx = beat_q - BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rdv_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (state_q == VLOAD)
                rdv_q[N*cap_idx +: N] <= mem_rdata;
            else if (state_q == VDRAIN)
                rdv_q[V-N +: N] <= mem_rdata;
        end
    end

    assign ReadDataVM = rdv_q;
    assign ReadDataM  = mem_rdata;
endmodule

// File: tb/tb_vector_mem_access.sv
// Directed bench for vector_mem_access with a word-addressed synchronous memory model and write log.
module tb_vector_mem_access;
    logic         clk = 1'b0;
    logic         rst;
    logic         MemWriteM, MemtoRegM, MemDataVM;
    logic [31:0]  ALUResultM, WriteDataM;
    logic [255:0] WriteDataVM;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata, ReadDataM;
    logic         mem_we, stall_req, misalign_err;
    logic [255:0] ReadDataVM;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] log_a [$];
    logic [31:0] log_d [$];

    vector_mem_access dut (
        .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .MemDataVM(MemDataVM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .WriteDataVM(WriteDataVM), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
        .ReadDataVM(ReadDataVM), .stall_req(stall_req), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[11:2]];
        if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM = 0; MemtoRegM = 0; MemDataVM = 0;
        ALUResultM = 0; WriteDataM = 0; WriteDataVM = '0;
    endtask

    task automatic set_vec(input logic st, input logic [31:0] base);
        MemDataVM = 1; MemWriteM = st; MemtoRegM = ~st; ALUResultM = base;
        for (int i = 0; i < 8; i++) WriteDataVM[32*i +: 32] = 32'(i);
    endtask

    // Runs until stall drops (the DONE cycle), returning the number of stalled cycles.
    task automatic run_vec(output int nstall);
        nstall = 0;
        while (stall_req === 1'b1 && nstall < 20) begin
            nstall++;
            tick();
        end
    endtask

    task automatic scalar_write(input logic [31:0] a, input logic [31:0] d);
        idle_inputs();
        MemWriteM = 1; ALUResultM = a; WriteDataM = d;
        tick();
        idle_inputs();
    endtask

    task automatic check_log(input string nm, input logic [31:0] base);
        checks++;
        if (log_a.size() != 8) begin
            errors++;
            $display("FAIL %s log size got %0d want 8", nm, log_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_a[i] !== base + 32'(4*i) || log_d[i] !== 32'(i)) begin
                    errors++;
                    $display("FAIL %s beat %0d got %h/%h want %h/%h", nm, i,
                             log_a[i], log_d[i], base + 32'(4*i), 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        checks++;
        if (stall_req !== 0 || mem_we !== 0 || misalign_err !== 0 || ReadDataVM !== '0) begin
            errors++;
            $display("FAIL reset got stall=%b we=%b mis=%b rdv=%h want 0s",
                     stall_req, mem_we, misalign_err, ReadDataVM);
        end
    endtask

    task automatic test_scalar_store();
        MemWriteM = 1; ALUResultM = 32'h10; WriteDataM = 32'hDEADBEEF;
        #1;
        checks++;
        if (mem_we !== 1 || stall_req !== 0 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL scalar_store got we=%b stall=%b a=%h d=%h want 1 0 10 deadbeef",
                     mem_we, stall_req, mem_addr, mem_wdata);
        end
        tick();
        idle_inputs();
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL scalar_mem got %h want deadbeef", mem[4]);
        end
    endtask

    task automatic vstore(input string nm, input logic [31:0] base, input logic [31:0] logbase);
        int ns;
        log_a.delete(); log_d.delete();
        set_vec(1, base);
        #1;
        run_vec(ns);
        checks++;
        if (ns != 8 || mem_we !== 0) begin
            errors++;
            $display("FAIL %s stall cycles got %0d we=%b want 8 0", nm, ns, mem_we);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_req !== 0) begin
            errors++;
            $display("FAIL %s idle after done got stall=%b want 0", nm, stall_req);
        end
        check_log(nm, logbase);
    endtask

    task automatic test_vector_store();
        vstore("vstore", 32'h100, 32'h100);
    endtask

    task automatic test_vector_load();
        int ns;
        for (int i = 0; i < 8; i++) scalar_write(32'h200 + 32'(4*i), 32'hA0 + 32'(i));
        set_vec(0, 32'h200);
        #1;
        run_vec(ns);
        checks++;
        if (ns != 9) begin
            errors++;
            $display("FAIL vload stall cycles got %0d want 9", ns);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ReadDataVM[32*i +: 32] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL vload word %0d got %h want %h", i, ReadDataVM[32*i +: 32], 32'hA0 + 32'(i));
            end
        end
        tick();
        idle_inputs();
        MemtoRegM = 1; ALUResultM = 32'h204;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ReadDataM !== 32'hA1) begin
            errors++;
            $display("FAIL scalar_load got %h want a1", ReadDataM);
        end
        scalar_write(32'h300, 32'h55);
        checks++;
        if (ReadDataVM[31:0] !== 32'hA0 || ReadDataVM[255:224] !== 32'hA7) begin
            errors++;
            $display("FAIL vload_hold got %h want a0..a7", ReadDataVM);
        end
    endtask

    task automatic test_wrap();
        vstore("wrap", 32'hFFFFFFF0, 32'hFFFFFFF0);
    endtask

    task automatic test_reset_mid();
        set_vec(0, 32'h200);
        tick(); tick(); tick();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        #1;
        checks++;
        if (stall_req !== 0 || ReadDataVM !== '0 || mem_we !== 0) begin
            errors++;
            $display("FAIL reset_mid got stall=%b we=%b rdv=%h want 0s", stall_req, mem_we, ReadDataVM);
        end
        MemWriteM = 1; ALUResultM = 32'h40;
        #1;
        checks++;
        if (mem_we !== 1 || stall_req !== 0) begin
            errors++;
            $display("FAIL reset_mid_idle got we=%b stall=%b want 1 0", mem_we, stall_req);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_misalign();
`ifdef VMEM_ALIGN_CHECK_EN
        set_vec(1, 32'h102);
        #1;
        checks++;
        if (misalign_err !== 1 || mem_we !== 0 || stall_req !== 0) begin
            errors++;
            $display("FAIL misalign got mis=%b we=%b stall=%b want 1 0 0", misalign_err, mem_we, stall_req);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_req !== 0 || misalign_err !== 0) begin
            errors++;
            $display("FAIL misalign_after got stall=%b mis=%b want 0 0", stall_req, misalign_err);
        end
`else
        set_vec(1, 32'h102);
        #1;
        checks++;
        if (misalign_err !== 0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL misalign_mask got mis=%b a=%h want 0 100", misalign_err, mem_addr);
        end
        idle_inputs();
        vstore("misalign", 32'h102, 32'h100);
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_scalar_store();
        test_vector_store();
        test_vector_load();
        test_wrap();
        test_reset_mid();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
